radar_burst_controller: RTL and testbench
=========================================

# radar_burst_controller

Parametrised successor to the single-pulse radar sequencer. It sequences bursts of N chirps, or continuous operation, at a programmable pulse repetition period. It gates ADC capture per channel, optionally hands each pulse to the Ethernet transmit path, and supervises the DAC with a chirp timeout. The block is single-clock (aclk) and sits between the host register bank and the DAC chirp / ADC capture / data-TX engines; CDC to the fmc150 and eth clocks is done outside this block.

## Interface
- CNT_W, 32, width of the PRP, collect and timeout counters
- NUM_CH, 2, number of ADC channels gated
- PROC_CYCLES, 2, fixed PROCESS state length (≥1)
- OVH_CYCLES, 2, fixed OVERHEAD state length (≥1)
- CHIRP_TIMEOUT, 65536, maximum CHIRP state cycles before error (≥2)

- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- arm  in  1  start request, sampled in IDLE
- abort  in  1  stop request, any state
- continuous  in  1  1 = repeat pulses until abort
- tx_en  in  1  1 = transmit each pulse's data
- prp_count  in  CNT_W  ACTIVE wait cycles per pulse (0 treated as 1)
- collect_count  in  CNT_W  COLLECT cycles (0 treated as 1)
- pulses_per_burst  in  16  N (0 treated as 1)
- ch_mask  in  NUM_CH  per-channel ADC enable
- chirp_ready  in  1  DAC ready (level)
- chirp_done  in  1  DAC chirp finished (1-cycle pulse)
- data_tx_ready  in  1  TX path ready (level)
- data_tx_done  in  1  TX finished (1-cycle pulse)
- chirp_init  out  1  1-cycle chirp start
- chirp_enable  out  1  high in CHIRP
- adc_enable  out  NUM_CH  per-channel capture gate
- data_tx_init  out  1  1-cycle TX start
- data_tx_enable  out  1  high in TRANSMIT
- busy  out  1  state ≠ IDLE
- pulse_index  out  16  current pulse number within burst, 0-based
- burst_done  out  1  1-cycle pulse on normal burst completion
- timeout_err  out  1  sticky; cleared only on arm accepted or reset

## Operation
- States: IDLE, ACTIVE, CHIRP, COLLECT, PROCESS, WAIT_TX, TRANSMIT, OVERHEAD.
- Config latching: continuous, tx_en, prp_count, collect_count, pulses_per_burst and ch_mask are latched on the IDLE→ACTIVE transition and are stable for the whole burst.
- IDLE→ACTIVE: arm & chirp_ready & !abort. The same transition clears pulse_index and timeout_err.
- ACTIVE: the counter is loaded with max(prp,1) on entry and decrements each cycle. Once it reaches 0 and chirp_ready=1, the next state is CHIRP. If chirp_ready=0, the block holds in ACTIVE.
- CHIRP: the next state is COLLECT on chirp_done. If the cycle count in CHIRP reaches CHIRP_TIMEOUT without chirp_done, the block sets timeout_err and goes to OVERHEAD, ending the burst with no burst_done.
- COLLECT: lasts max(collect_count,1) cycles, then PROCESS.
- PROCESS: lasts PROC_CYCLES cycles, then WAIT_TX if tx_en is latched, otherwise OVERHEAD.
- WAIT_TX→TRANSMIT: on data_tx_ready.
- TRANSMIT→OVERHEAD: on data_tx_done.
- OVERHEAD: lasts OVH_CYCLES cycles, then:
  - timeout path: IDLE;
  - continuous: ACTIVE, pulse_index increments and wraps at 0xFFFF;
  - pulse_index == N−1: IDLE with burst_done;
  - otherwise: ACTIVE, pulse_index+1.
- abort: the next state is IDLE from any state. Priority is abort > timeout > normal transition. All enables deassert the following cycle, burst_done is not asserted, and pulse_index holds its value.
- Simultaneous events:
  - chirp_done in the same cycle the timeout expires counts as done, with no error;
  - arm & abort together in IDLE leaves the block in IDLE;
  - data_tx_done in the first TRANSMIT cycle is ignored.

## Timing
- All outputs are registered. After reset: state IDLE and every output 0, including pulse_index and timeout_err.
- chirp_init is high exactly in the first cycle that state = CHIRP. data_tx_init is high exactly in the first cycle of TRANSMIT.
- chirp_enable equals (state==CHIRP), data_tx_enable equals (state==TRANSMIT), busy equals (state≠IDLE); all are coincident with state.
- adc_enable[i] equals ch_mask_latched[i] & (state==CHIRP | state==COLLECT).
- burst_done is high in the first IDLE cycle after the final OVERHEAD.
- Pulse period with tx off equals max(prp,1) + chirp cycles + max(collect,1) + PROC_CYCLES + OVH_CYCLES.
- Counters saturate at 0 and never underflow.

## Test plan
- Reset, then arm with chirp_ready=1, prp=10, collect=5, N=1, tx_en=0, chirp_done 20 cycles into CHIRP. Required: ACTIVE lasts 10 cycles; chirp_init is a single pulse; adc_enable is high for 25 cycles; burst_done fires once; busy is low afterwards.
- N=3 with prp=4. Required: three chirp_init pulses, 4 + chirp + 1 + 2 + 2 cycles apart in steady state; pulse_index reads 0, 1, 2; exactly one burst_done.
- tx_en=1, data_tx_ready held low 7 cycles, data_tx_done 12 cycles after data_tx_init. Required: 7 cycles in WAIT_TX; one data_tx_init; data_tx_enable high for 13 cycles.
- CHIRP_TIMEOUT=16, chirp_done never arrives. Required: CHIRP lasts 16 cycles; timeout_err=1 and stays set; OVERHEAD then IDLE; no burst_done; a new arm clears timeout_err.
- continuous=1, ch_mask=2'b10: abort during COLLECT of pulse 5. Required: IDLE the next cycle; adc_enable goes 00 the following cycle with adc_enable[0] never high; pulse_index=5; no burst_done.
- prp=0, collect=0, N=0. Required: behaves as 1/1/1. Also hold aresetn low mid-TRANSMIT: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/radar_burst_controller.sv
// radar_burst_controller
//   Sequences bursts of N chirps (or continuous pulses) at a programmable
//   pulse repetition period, gates per-channel ADC capture, optionally hands
//   each pulse to the TX path, and supervises the DAC with a chirp timeout.
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   arm, abort           start (sampled in IDLE) / stop (any state)
//   continuous, tx_en,
//   prp_count, collect_count, pulses_per_burst, ch_mask
//                        burst config, latched on IDLE->ACTIVE
//   chirp_ready/done     DAC handshake
//   data_tx_ready/done   TX handshake
//   chirp_init/enable, adc_enable, data_tx_init/enable, busy,
//   pulse_index, burst_done, timeout_err   registered status/control outputs
module radar_burst_controller #(
  parameter int CNT_W         = 32,
  parameter int NUM_CH        = 2,
  parameter int PROC_CYCLES   = 2,
  parameter int OVH_CYCLES    = 2,
  parameter int CHIRP_TIMEOUT = 65536
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              arm,
  input  logic              abort,
  input  logic              continuous,
  input  logic              tx_en,
  input  logic [CNT_W-1:0]  prp_count,
  input  logic [CNT_W-1:0]  collect_count,
  input  logic [15:0]       pulses_per_burst,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              chirp_ready,
  input  logic              chirp_done,
  input  logic              data_tx_ready,
  input  logic              data_tx_done,
  output logic              chirp_init,
  output logic              chirp_enable,
  output logic [NUM_CH-1:0] adc_enable,
  output logic              data_tx_init,
  output logic              data_tx_enable,
  output logic              busy,
  output logic [15:0]       pulse_index,
  output logic              burst_done,
  output logic              timeout_err
);

  localparam int TO_W = $clog2(CHIRP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PROC_LD = CNT_W'(PROC_CYCLES);
  localparam logic [CNT_W-1:0] OVH_LD  = CNT_W'(OVH_CYCLES);
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(CHIRP_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, ACTIVE, CHIRP, COLLECT, PROCESS, WAIT_TX, TRANSMIT, OVERHEAD
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_dec;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [15:0]       pidx_q, pidx_d;
  logic              terr_q, terr_d, bdone_d;
  // latched burst configuration (zero counts already promoted to 1)
  logic              cont_q, cont_d, txen_q, txen_d;
  logic [CNT_W-1:0]  prp_q, prp_d, coll_q, coll_d;
  logic [15:0]       n_q, n_d;
  logic [NUM_CH-1:0] mask_q, mask_d;

  assign cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - ONE;
  assign pulse_index = pidx_q;
  assign timeout_err = terr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    pidx_d  = pidx_q;
    terr_d  = terr_q;
    bdone_d = 1'b0;
    cont_d  = cont_q;
    txen_d  = txen_q;
    prp_d   = prp_q;
    coll_d  = coll_q;
    n_d     = n_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: if (arm && chirp_ready && !abort) begin
        state_d = ACTIVE;
        cont_d  = continuous;
        txen_d  = tx_en;
        prp_d   = (prp_count == '0) ? ONE : prp_count;
        coll_d  = (collect_count == '0) ? ONE : collect_count;
        n_d     = (pulses_per_burst == 16'd0) ? 16'd1 : pulses_per_burst;
        mask_d  = ch_mask;
        cnt_d   = (prp_count == '0) ? ONE : prp_count;
        pidx_d  = 16'd0;
        terr_d  = 1'b0;
      end
      // counter value 1 is the last cycle; 0 means waiting on chirp_ready
      ACTIVE: begin
        cnt_d = cnt_dec;
        if (cnt_q <= ONE && chirp_ready) begin
          state_d = CHIRP;
          tcnt_d  = TO_W'(1);
        end
      end
      // chirp_done wins over a timeout expiring in the same cycle
      CHIRP: begin
        if (chirp_done) begin
          state_d = COLLECT;
          cnt_d   = coll_q;
        end else if (tcnt_q >= TO_LIM) begin
          state_d = OVERHEAD;
          cnt_d   = OVH_LD;
          terr_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      COLLECT: begin
        cnt_d = cnt_dec;
        if (cnt_q <= ONE) begin
          state_d = PROCESS;
          cnt_d   = PROC_LD;
        end
      end
      PROCESS: begin
        cnt_d = cnt_dec;
        if (cnt_q <= ONE) begin
          state_d = txen_q ? WAIT_TX : OVERHEAD;
          cnt_d   = txen_q ? '0 : OVH_LD;
        end
      end
      WAIT_TX: if (data_tx_ready) state_d = TRANSMIT;
      // data_tx_init is high only in the first TRANSMIT cycle; a done
      // seen there belongs to a previous transfer and is ignored
      TRANSMIT: if (data_tx_done && !data_tx_init) begin
        state_d = OVERHEAD;
        cnt_d   = OVH_LD;
      end
      OVERHEAD: begin
        cnt_d = cnt_dec;
        if (cnt_q <= ONE) begin
          if (terr_q) begin
            state_d = IDLE;
          end else if (cont_q || pidx_q != n_q - 16'd1) begin
            state_d = ACTIVE;
            pidx_d  = pidx_q + 16'd1;
            cnt_d   = prp_q;
          end else begin
            state_d = IDLE;
            bdone_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a timeout in the same cycle
    if (abort) begin
      state_d = IDLE;
      bdone_d = 1'b0;
      pidx_d  = pidx_q;
      terr_d  = terr_q;
    end
  end

  // outputs are decoded from the next state so they line up with state_q
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      pidx_q         <= '0;
      terr_q         <= 1'b0;
      cont_q         <= 1'b0;
      txen_q         <= 1'b0;
      prp_q          <= ONE;
      coll_q         <= ONE;
      n_q            <= 16'd1;
      mask_q         <= '0;
      chirp_init     <= 1'b0;
      chirp_enable   <= 1'b0;
      adc_enable     <= '0;
      data_tx_init   <= 1'b0;
      data_tx_enable <= 1'b0;
      busy           <= 1'b0;
      burst_done     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tcnt_q         <= tcnt_d;
      pidx_q         <= pidx_d;
      terr_q         <= terr_d;
      cont_q         <= cont_d;
      txen_q         <= txen_d;
      prp_q          <= prp_d;
      coll_q         <= coll_d;
      n_q            <= n_d;
      mask_q         <= mask_d;
      chirp_init     <= (state_d == CHIRP) && (state_q != CHIRP);
      chirp_enable   <= (state_d == CHIRP);
      adc_enable     <= mask_d & {NUM_CH{(state_d == CHIRP) || (state_d == COLLECT)}};
      data_tx_init   <= (state_d == TRANSMIT) && (state_q != TRANSMIT);
      data_tx_enable <= (state_d == TRANSMIT);
      busy           <= (state_d != IDLE);
      burst_done     <= bdone_d;
    end
  end

endmodule

// File: tb/tb_radar_burst_controller.sv
// Directed bench for radar_burst_controller: a default-timeout instance for
// the burst/tx/abort scenarios and a CHIRP_TIMEOUT=16 instance for timeout.
module tb_radar_burst_controller;
  logic aclk, aresetn, arm, abort, continuous, tx_en;
  logic [31:0] prp_count, collect_count;
  logic [15:0] pulses_per_burst;
  logic [1:0]  ch_mask;
  logic chirp_ready, chirp_done, data_tx_ready, data_tx_done;

  logic chirp_init, chirp_enable, data_tx_init, data_tx_enable, busy, burst_done, timeout_err;
  logic [1:0]  adc_enable;
  logic [15:0] pulse_index;
  logic to_chirp_init, to_chirp_enable, to_data_tx_init, to_data_tx_enable, to_busy, to_burst_done, to_timeout_err;
  logic [1:0]  to_adc_enable;
  logic [15:0] to_pulse_index;

  int total = 0, bad = 0;
  // per-burst observations filled in by run_burst
  int n_init, n_adc, n_adc0, n_bd, n_txi, n_txe, gap_init, end_t, abort_t, exit_pidx;
  int init_t [0:7];
  int pidx_r [0:7];

  radar_burst_controller u_dut (
    .aclk(aclk), .aresetn(aresetn), .arm(arm), .abort(abort), .continuous(continuous),
    .tx_en(tx_en), .prp_count(prp_count), .collect_count(collect_count),
    .pulses_per_burst(pulses_per_burst), .ch_mask(ch_mask), .chirp_ready(chirp_ready),
    .chirp_done(chirp_done), .data_tx_ready(data_tx_ready), .data_tx_done(data_tx_done),
    .chirp_init(chirp_init), .chirp_enable(chirp_enable), .adc_enable(adc_enable),
    .data_tx_init(data_tx_init), .data_tx_enable(data_tx_enable), .busy(busy),
    .pulse_index(pulse_index), .burst_done(burst_done), .timeout_err(timeout_err));

  radar_burst_controller #(.CHIRP_TIMEOUT(16)) u_to (
    .aclk(aclk), .aresetn(aresetn), .arm(arm), .abort(abort), .continuous(continuous),
    .tx_en(tx_en), .prp_count(prp_count), .collect_count(collect_count),
    .pulses_per_burst(pulses_per_burst), .ch_mask(ch_mask), .chirp_ready(chirp_ready),
    .chirp_done(chirp_done), .data_tx_ready(data_tx_ready), .data_tx_done(data_tx_done),
    .chirp_init(to_chirp_init), .chirp_enable(to_chirp_enable), .adc_enable(to_adc_enable),
    .data_tx_init(to_data_tx_init), .data_tx_enable(to_data_tx_enable), .busy(to_busy),
    .pulse_index(to_pulse_index), .burst_done(to_burst_done), .timeout_err(to_timeout_err));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr_in();
    arm = 0; abort = 0; chirp_done = 0; data_tx_ready = 0; data_tx_done = 0;
  endtask

  task automatic do_reset();
    clr_in();
    aresetn = 0; step(); step();
    aresetn = 1; step();
  endtask

  task automatic set_cfg(input int prp, input int coll, input int n, input logic tx,
                         input logic cont, input logic [1:0] mask);
    prp_count = prp; collect_count = coll; pulses_per_burst = n[15:0];
    tx_en = tx; continuous = cont; ch_mask = mask; chirp_ready = 1;
  endtask

  // Arms, then plays DAC/TX peer: chirp_done in CHIRP cycle done_at, tx ready
  // once rdy_at idle cycles have elapsed since COLLECT, tx done in TRANSMIT
  // cycle 1 (must be ignored) and txdone_at cycles after data_tx_init, abort
  // in the first COLLECT cycle of pulse abort_pidx. t=1 is the first ACTIVE cycle.
  task automatic run_burst(input int max_cyc, input int done_at, input int rdy_at,
                           input int txdone_at, input int abort_pidx);
    int t, cc, txc, gap;
    n_init = 0; n_adc = 0; n_adc0 = 0; n_bd = 0; n_txi = 0; n_txe = 0;
    gap_init = -1; abort_t = -1;
    cc = 0; txc = 0; gap = 0;
    arm = 1; step(); arm = 0;
    t = 1;
    while (1) begin
      cc  = chirp_enable ? cc + 1 : 0;
      txc = data_tx_enable ? txc + 1 : 0;
      if (adc_enable != 2'b00) gap = 0;
      else if (busy && !data_tx_enable) gap++;
      if (chirp_init) begin
        if (n_init < 8) begin init_t[n_init] = t; pidx_r[n_init] = pulse_index; end
        n_init++;
      end
      if (adc_enable != 2'b00) n_adc++;
      if (adc_enable[0]) n_adc0++;
      if (burst_done) n_bd++;
      if (data_tx_init) begin n_txi++; gap_init = gap; end
      if (data_tx_enable) n_txe++;
      if (!busy || t >= max_cyc) break;
      chirp_done    = chirp_enable && cc == done_at;
      data_tx_ready = gap >= rdy_at;
      data_tx_done  = data_tx_enable && (txc == 1 || txc == txdone_at + 1);
      abort = abort_pidx >= 0 && pulse_index == abort_pidx[15:0] &&
              adc_enable != 2'b00 && !chirp_enable;
      if (abort && abort_t < 0) abort_t = t;
      step(); t++;
    end
    end_t = t; exit_pidx = pulse_index;
    clr_in();
  endtask

  task automatic test_reset();
    set_cfg(1, 1, 1, 0, 0, 2'b11);
    clr_in();
    aresetn = 0; step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if ({chirp_init, chirp_enable, adc_enable, data_tx_init, data_tx_enable} !== 6'b0) begin bad++; $display("FAIL rst_enables: got %b want 0", {chirp_init, chirp_enable, adc_enable, data_tx_init, data_tx_enable}); end
    total++; if ({pulse_index, burst_done, timeout_err} !== 18'b0) begin bad++; $display("FAIL rst_status: got %h want 0", {pulse_index, burst_done, timeout_err}); end
    aresetn = 1; step();
    arm = 1; abort = 1; step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arm_abort_idle: got busy=%b want 0", busy); end
    abort = 0; chirp_ready = 0; step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arm_not_ready: got busy=%b want 0", busy); end
    arm = 0; chirp_ready = 1;
  endtask

  task automatic test_single();
    do_reset();
    set_cfg(10, 5, 1, 0, 0, 2'b11);
    run_burst(200, 20, 0, 100, -1);
    total++; if (init_t[0] !== 11) begin bad++; $display("FAIL t1_active_len: got init at %0d want 11", init_t[0]); end
    total++; if (n_init !== 1) begin bad++; $display("FAIL t1_inits: got %0d want 1", n_init); end
    total++; if (n_adc !== 25) begin bad++; $display("FAIL t1_adc_cycles: got %0d want 25", n_adc); end
    total++; if (n_bd !== 1 || burst_done !== 1'b1) begin bad++; $display("FAIL t1_burst_done: got %0d/%b want 1/1", n_bd, burst_done); end
    total++; if (end_t !== 40) begin bad++; $display("FAIL t1_period: got idle at %0d want 40", end_t); end
    step();
    total++; if (busy !== 1'b0 || burst_done !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL t1_after: got busy=%b bd=%b err=%b want 0/0/0", busy, burst_done, timeout_err); end
  endtask

  task automatic test_multi_pulse();
    do_reset();
    set_cfg(4, 1, 3, 0, 0, 2'b11);
    run_burst(200, 3, 0, 100, -1);
    total++; if (n_init !== 3) begin bad++; $display("FAIL t2_inits: got %0d want 3", n_init); end
    total++; if (init_t[0] !== 5 || init_t[1] !== 17 || init_t[2] !== 29) begin bad++; $display("FAIL t2_spacing: got %0d,%0d,%0d want 5,17,29", init_t[0], init_t[1], init_t[2]); end
    total++; if (pidx_r[0] !== 0 || pidx_r[1] !== 1 || pidx_r[2] !== 2) begin bad++; $display("FAIL t2_pidx: got %0d,%0d,%0d want 0,1,2", pidx_r[0], pidx_r[1], pidx_r[2]); end
    total++; if (n_bd !== 1 || end_t !== 37) begin bad++; $display("FAIL t2_done: got bd=%0d at %0d want 1 at 37", n_bd, end_t); end
  endtask

  task automatic test_transmit();
    do_reset();
    set_cfg(2, 3, 1, 1, 0, 2'b11);
    run_burst(200, 2, 9, 12, -1);
    total++; if (gap_init !== 9) begin bad++; $display("FAIL t3_wait_tx: got %0d idle cycles want 9 (2 process + 7 wait)", gap_init); end
    total++; if (n_txi !== 1) begin bad++; $display("FAIL t3_tx_init: got %0d want 1", n_txi); end
    total++; if (n_txe !== 13) begin bad++; $display("FAIL t3_tx_enable: got %0d want 13", n_txe); end
    total++; if (end_t !== 32 || n_bd !== 1) begin bad++; $display("FAIL t3_end: got t=%0d bd=%0d want 32/1", end_t, n_bd); end
  endtask

  task automatic test_timeout();
    int chirp_c, post_c, bd;
    logic fin;
    do_reset();
    set_cfg(1, 1, 1, 0, 0, 2'b11);
    chirp_c = 0; post_c = 0; bd = 0; fin = 0;
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 100; i++) begin
      if (to_chirp_enable) chirp_c++;
      else if (chirp_c > 0 && to_busy) post_c++;
      if (to_burst_done) bd++;
      if (chirp_c > 0 && !to_busy) begin fin = 1; break; end
      step();
    end
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL t4_bound: got fin=%b want 1", fin); end
    total++; if (chirp_c !== 16) begin bad++; $display("FAIL t4_chirp_len: got %0d want 16", chirp_c); end
    total++; if (post_c !== 2) begin bad++; $display("FAIL t4_overhead: got %0d want 2", post_c); end
    total++; if (to_timeout_err !== 1'b1) begin bad++; $display("FAIL t4_err_set: got %b want 1", to_timeout_err); end
    step(); step(); step();
    total++; if (to_timeout_err !== 1'b1 || bd !== 0 || to_burst_done !== 1'b0) begin bad++; $display("FAIL t4_sticky: got err=%b bd=%0d want 1/0", to_timeout_err, bd); end
    arm = 1; step(); arm = 0;
    total++; if (to_timeout_err !== 1'b0 || to_busy !== 1'b1) begin bad++; $display("FAIL t4_rearm: got err=%b busy=%b want 0/1", to_timeout_err, to_busy); end
  endtask

  task automatic test_abort();
    do_reset();
    set_cfg(1, 6, 2, 0, 1, 2'b10);
    run_burst(400, 1, 0, 100, 5);
    total++; if (abort_t < 0 || end_t !== abort_t + 1) begin bad++; $display("FAIL t5_idle_next: got abort %0d idle %0d want idle=abort+1", abort_t, end_t); end
    total++; if (exit_pidx !== 5 || n_init !== 6) begin bad++; $display("FAIL t5_pidx: got pidx=%0d inits=%0d want 5/6", exit_pidx, n_init); end
    total++; if (adc_enable !== 2'b00) begin bad++; $display("FAIL t5_adc_off: got %b want 00", adc_enable); end
    total++; if (n_adc0 !== 0 || n_bd !== 0) begin bad++; $display("FAIL t5_mask_bd: got adc0=%0d bd=%0d want 0/0", n_adc0, n_bd); end
    step();
    total++; if (adc_enable !== 2'b00 || burst_done !== 1'b0 || pulse_index !== 16'd5) begin bad++; $display("FAIL t5_hold: got adc=%b bd=%b pidx=%0d want 00/0/5", adc_enable, burst_done, pulse_index); end
  endtask

  task automatic test_zero_cfg();
    logic fin;
    do_reset();
    set_cfg(0, 0, 0, 0, 0, 2'b11);
    run_burst(50, 1, 0, 100, -1);
    total++; if (init_t[0] !== 2 || n_init !== 1) begin bad++; $display("FAIL t6_prp0: got init at %0d n=%0d want 2/1", init_t[0], n_init); end
    total++; if (n_adc !== 2) begin bad++; $display("FAIL t6_collect0: got %0d want 2", n_adc); end
    total++; if (end_t !== 8 || n_bd !== 1) begin bad++; $display("FAIL t6_n0: got t=%0d bd=%0d want 8/1", end_t, n_bd); end
    // reset while transmitting
    set_cfg(1, 1, 1, 1, 0, 2'b11);
    data_tx_ready = 1; fin = 0;
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 50; i++) begin
      if (chirp_enable) chirp_done = 1; else chirp_done = 0;
      if (data_tx_enable) begin fin = 1; break; end
      step();
    end
    chirp_done = 0;
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL t6_reach_tx: got fin=%b want 1", fin); end
    step(); step();
    aresetn = 0; step();
    total++; if ({chirp_init, chirp_enable, adc_enable, data_tx_init, data_tx_enable, busy, burst_done, timeout_err, pulse_index} !== 25'b0) begin bad++; $display("FAIL t6_reset_tx: got %h want 0", {chirp_init, chirp_enable, adc_enable, data_tx_init, data_tx_enable, busy, burst_done, timeout_err, pulse_index}); end
    aresetn = 1; clr_in(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_pulse();
    test_transmit();
    test_timeout();
    test_abort();
    test_zero_cfg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
